// File: rtl/br_pred_arb.sv
// gshare PHT port arbiter: shares one single-port SRAM between fetch lookups and
// queued commit-side read-modify-write updates, owns both GHRs and sweeps the table after reset.
module br_pred_arb #(
  parameter int ADDR   = 32,
  parameter int CNT    = 2,
  parameter int IDX    = 10,
  parameter int QDEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_,
  input  logic            lookup_req_,
  input  logic [ADDR-1:0] lookup_pc,
  output logic            lookup_gnt_,
  output logic            pred_valid_,
  output logic            br_pred,
  input  logic            br_commit_,
  input  logic [ADDR-1:0] commit_pc,
  input  logic            br_result,
  input  logic            br_pred_miss_,
  output logic            commit_stall_,
  output logic            pht_en_,
  output logic            pht_we_,
  output logic [IDX-1:0]  pht_addr,
  output logic [CNT-1:0]  pht_wdata,
  input  logic [CNT-1:0]  pht_rdata,
  output logic [1:0]      o_dbg_state
);

  localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [CNT-1:0] CNT_WEAK_NT = CNT'((1 << (CNT - 1)) - 1);
  localparam logic [CNT-1:0] CNT_MAX     = '1;
  localparam logic [CNT-1:0] CNT_ONE     = CNT'(1);
  localparam logic [IDX-1:0] IDX_LAST    = '1;
  localparam logic [IDX-1:0] IDX_ONE     = IDX'(1);
  localparam logic [QW-1:0]  PTR_ONE     = QW'(1);
  localparam logic [QW:0]    CNT_Q_ONE   = (QW + 1)'(1);
  localparam logic [QW:0]    Q_FULL      = (QW + 1)'(QDEPTH);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_UPD_WR = 2'd2
  } state_t;

  state_t            r_state;
  logic [IDX-1:0]    r_init_cnt;
  logic [IDX-1:0]    r_spec_ghr;
  logic [IDX-1:0]    r_cmt_ghr;
  logic [IDX-1:0]    r_q_idx [QDEPTH];
  logic [QDEPTH-1:0] r_q_res;
  logic [QW-1:0]     r_wr_ptr;
  logic [QW-1:0]     r_rd_ptr;
  logic [QW:0]       r_count;
  logic              r_lk_pend;

  logic           w_full;
  logic           w_empty;
  logic           w_upd_sel;
  logic           w_grant;
  logic           w_push;
  logic           w_pop;
  logic           w_recover;
  logic           w_pred_fire;
  logic [IDX-1:0] w_lk_idx;
  logic [IDX-1:0] w_cm_idx;
  logic [IDX-1:0] w_cmt_ghr_nxt;
  logic [IDX-1:0] w_head_idx;
  logic           w_head_res;
  logic [CNT-1:0] w_upd_cnt;
  logic           w_unused;

  assign w_unused = ^{lookup_pc[ADDR-1:IDX+2], lookup_pc[1:0],
                      commit_pc[ADDR-1:IDX+2], commit_pc[1:0]};

  assign w_lk_idx   = lookup_pc[IDX+1:2] ^ r_spec_ghr;
  assign w_cm_idx   = commit_pc[IDX+1:2] ^ r_cmt_ghr;
  assign w_full     = (r_count == Q_FULL);
  assign w_empty    = (r_count == '0);
  assign w_head_idx = r_q_idx[r_rd_ptr];
  assign w_head_res = r_q_res[r_rd_ptr];

  // Commit handshake: a commit transfers on a cycle where br_commit_ is low and
  // commit_stall_ is high; a lookup transfers where lookup_req_ and lookup_gnt_ are both low.
  assign commit_stall_ = ~(w_full | (r_state == ST_INIT));
  assign w_push        = ~br_commit_ & commit_stall_;
  assign w_pop         = (r_state == ST_UPD_WR);
  assign w_upd_sel     = (r_state == ST_IDLE) & ~w_empty & (lookup_req_ | w_full);
  assign w_grant       = (r_state == ST_IDLE) & ~w_upd_sel & ~lookup_req_;
  assign lookup_gnt_   = ~w_grant;

  assign w_cmt_ghr_nxt = w_push ? {r_cmt_ghr[IDX-2:0], br_result} : r_cmt_ghr;
  assign w_recover     = (w_push & ~br_pred_miss_) | ~flush_;

  // A recovery cycle drops the returning prediction so the restored history is not polluted.
  assign w_pred_fire = r_lk_pend & ~w_recover;
  assign pred_valid_ = ~w_pred_fire;
  assign br_pred     = w_pred_fire & pht_rdata[CNT-1];

  assign w_upd_cnt = w_head_res ? ((pht_rdata == CNT_MAX) ? CNT_MAX : pht_rdata + CNT_ONE)
                                : ((pht_rdata == '0) ? '0 : pht_rdata - CNT_ONE);

  assign pht_en_ = reset | ~((r_state == ST_INIT) | (r_state == ST_UPD_WR) | w_upd_sel | w_grant);
  assign pht_we_ = reset | ~((r_state == ST_INIT) | (r_state == ST_UPD_WR));

  always_comb begin
    pht_addr  = '0;
    pht_wdata = '0;
    case (r_state)
      ST_INIT: begin
        pht_addr  = r_init_cnt;
        pht_wdata = CNT_WEAK_NT;
      end
      ST_UPD_WR: begin
        pht_addr  = w_head_idx;
        pht_wdata = w_upd_cnt;
      end
      default: begin
        if (w_upd_sel) pht_addr = w_head_idx;
        else if (w_grant) pht_addr = w_lk_idx;
      end
    endcase
  end

  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_spec_ghr <= '0;
      r_cmt_ghr  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_lk_pend  <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + IDX_ONE;
          if (r_init_cnt == IDX_LAST) r_state <= ST_IDLE;
        end
        ST_IDLE:   if (w_upd_sel) r_state <= ST_UPD_WR;
        ST_UPD_WR: r_state <= ST_IDLE;
        default:   r_state <= ST_INIT;
      endcase

      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_Q_ONE;
        2'b01:   r_count <= r_count - CNT_Q_ONE;
        default: r_count <= r_count;
      endcase

      r_cmt_ghr <= w_cmt_ghr_nxt;
      if (w_recover)        r_spec_ghr <= w_cmt_ghr_nxt;
      else if (w_pred_fire) r_spec_ghr <= {r_spec_ghr[IDX-2:0], br_pred};

      r_lk_pend <= w_grant;
    end
  end

  // Queue payload needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_idx[r_wr_ptr] <= w_cm_idx;
      r_q_res[r_wr_ptr] <= br_result;
    end
  end

endmodule
